// File: rtl/gray_pos_decoder.sv
// rtl/gray_pos_decoder.sv - Gray sample decoder with step/direction tracking and jump detection
module gray_pos_decoder #(
  parameter int WIDTH = 4,
  parameter int POS_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             gray_valid,
  input  logic             resync,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step,
  output logic             dir_up,
  output logic [POS_W-1:0] pos,
  output logic             err,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   bin_d;
  logic               bin_valid_d;
  logic               step_d;
  logic               dir_up_d;
  logic [POS_W-1:0]   pos_d;
  logic               err_d;
  logic [7:0]         err_count_d;
  logic [WIDTH-1:0]   new_bin;
  logic [WIDTH-1:0]   diff;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign new_bin = gray2bin(gray_in);
  // Modular distance from the reference; only +1 and -1 are legal moves.
  assign diff    = new_bin - bin_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SYNC;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      step      <= 1'b0;
      dir_up    <= 1'b1;
      pos       <= '0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_d;
      bin_out   <= bin_d;
      bin_valid <= bin_valid_d;
      step      <= step_d;
      dir_up    <= dir_up_d;
      pos       <= pos_d;
      err       <= err_d;
      err_count <= err_count_d;
    end
  end

  always_comb begin
    state_d     = state;
    bin_d       = bin_out;
    bin_valid_d = bin_valid;
    step_d      = 1'b0;
    dir_up_d    = dir_up;
    pos_d       = pos;
    err_d       = 1'b0;
    err_count_d = err_count;

    if (resync) begin
      // Resync drops the reference but keeps history (pos, dir, error tally).
      state_d     = ST_SYNC;
      bin_valid_d = 1'b0;
    end else if (gray_valid) begin
      case (state)
        ST_SYNC: begin
          bin_d       = new_bin;
          bin_valid_d = 1'b1;
          state_d     = ST_TRACK;
        end
        ST_TRACK: begin
          if (diff == WIDTH'(1)) begin
            bin_d    = new_bin;
            step_d   = 1'b1;
            dir_up_d = 1'b1;
            pos_d    = pos + POS_W'(1);
          end else if (diff == {WIDTH{1'b1}}) begin
            bin_d    = new_bin;
            step_d   = 1'b1;
            dir_up_d = 1'b0;
            pos_d    = pos - POS_W'(1);
          end else if (diff != '0) begin
            err_d       = 1'b1;
            bin_valid_d = 1'b0;
            state_d     = ST_FAULT;
            if (err_count != 8'hFF) begin
              err_count_d = err_count + 8'd1;
            end
          end
        end
        default: begin
          state_d = state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_pos_decoder.sv
// tb/tb_gray_pos_decoder.sv - self-checking bench for gray_pos_decoder
module tb_gray_pos_decoder;

  localparam int W = 4;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [W-1:0]  gray_in = '0;
  logic          gray_valid = 1'b0;
  logic          resync = 1'b0;
  logic [W-1:0]  bin_out;
  logic          bin_valid;
  logic          step;
  logic          dir_up;
  logic [PW-1:0] pos;
  logic          err;
  logic [7:0]    err_count;

  int n_total = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Reference model: 0 = no reference, 1 = tracking, 2 = faulted
  int m_mode, m_bin, m_bv, m_step, m_dir, m_pos, m_err, m_ec;

  gray_pos_decoder #(.WIDTH(W), .POS_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .gray_valid(gray_valid),
    .resync(resync), .bin_out(bin_out), .bin_valid(bin_valid), .step(step),
    .dir_up(dir_up), .pos(pos), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [W-1:0] to_gray(input int b);
    logic [W-1:0] v;
    v = W'(b);
    return v ^ (v >> 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int g, nb, d;
    if (!rst_n) begin
      m_mode <= 0; m_bin <= 0; m_bv <= 0; m_step <= 0;
      m_dir <= 1; m_pos <= 0; m_err <= 0; m_ec <= 0;
    end else begin
      m_step <= 0;
      m_err  <= 0;
      if (resync) begin
        m_mode <= 0;
        m_bv   <= 0;
      end else if (gray_valid) begin
        g  = int'(gray_in);
        nb = 0;
        for (int k = 0; k < W; k++) nb = nb ^ (g >> k);
        d = (nb - m_bin + (1 << W)) % (1 << W);
        if (m_mode == 0) begin
          m_bin <= nb; m_bv <= 1; m_mode <= 1;
        end else if (m_mode == 1) begin
          if (d == 1) begin
            m_bin <= nb; m_step <= 1; m_dir <= 1; m_pos <= (m_pos + 1) % (1 << PW);
          end else if (d == (1 << W) - 1) begin
            m_bin <= nb; m_step <= 1; m_dir <= 0; m_pos <= (m_pos + (1 << PW) - 1) % (1 << PW);
          end else if (d != 0) begin
            m_err <= 1; m_bv <= 0; m_mode <= 2;
            m_ec  <= (m_ec < 255) ? m_ec + 1 : 255;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("bin_out", 32'(bin_out), 32'(m_bin));
      check("bin_valid", 32'(bin_valid), 32'(m_bv));
      check("step", 32'(step), 32'(m_step));
      check("dir_up", 32'(dir_up), 32'(m_dir));
      check("pos", 32'(pos), 32'(m_pos));
      check("err", 32'(err), 32'(m_err));
      check("err_count", 32'(err_count), 32'(m_ec));
      check("step_err_excl", 32'(step & err), 32'd0);
    end
  end

  task automatic apply(input logic gv, input logic [W-1:0] g, input logic rs);
    @(negedge clk);
    gray_valid = gv;
    gray_in    = g;
    resync     = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_dir", 32'(dir_up), 32'd1);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    apply(1, 4'b1011, 0);
    check("sync_bin", 32'(bin_out), 32'hD);
    check("sync_valid", 32'(bin_valid), 32'd1);
    check("sync_step", 32'(step), 32'd0);
    check("sync_pos", 32'(pos), 32'd0);

    apply(1, 4'b1001, 0);
    check("up_bin", 32'(bin_out), 32'hE);
    check("up_step", 32'(step), 32'd1);
    check("up_pos", 32'(pos), 32'd1);
    apply(1, 4'b1001, 0);
    check("same_step", 32'(step), 32'd0);
    check("same_pos", 32'(pos), 32'd1);

    apply(1, 4'b1000, 0);
    apply(1, 4'b0000, 0);
    check("wrap_up_bin", 32'(bin_out), 32'h0);
    check("wrap_up_dir", 32'(dir_up), 32'd1);
    check("wrap_up_pos", 32'(pos), 32'd3);
    apply(1, 4'b1000, 0);
    check("wrap_dn_bin", 32'(bin_out), 32'hF);
    check("wrap_dn_dir", 32'(dir_up), 32'd0);
    check("wrap_dn_pos", 32'(pos), 32'd2);
    apply(1, 4'b0000, 0);

    apply(1, 4'b0011, 0);
    check("jump_err", 32'(err), 32'd1);
    check("jump_ec", 32'(err_count), 32'd1);
    check("jump_valid", 32'(bin_valid), 32'd0);
    check("jump_bin", 32'(bin_out), 32'h0);
    apply(1, 4'b0001, 0);
    check("fault_ignored", 32'(bin_out), 32'h0);
    check("fault_noerr", 32'(err), 32'd0);
    apply(1, 4'b0011, 1);
    check("resync_drop", 32'(bin_valid), 32'd0);
    apply(1, 4'b0011, 0);
    check("resync_bin", 32'(bin_out), 32'h2);
    check("resync_valid", 32'(bin_valid), 32'd1);
    apply(0, 4'b0110, 0);
    check("idle_bin", 32'(bin_out), 32'h2);

    apply(1, 4'b0010, 0);
    apply(0, 4'b0110, 0);
    apply(1, 4'b0110, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    gray_valid = 1'b1;
    #1;
    check("arst_bin", 32'(bin_out), 32'h0);
    check("arst_valid", 32'(bin_valid), 32'd0);
    check("arst_pos", 32'(pos), 32'd0);
    check("arst_dir", 32'(dir_up), 32'd1);
    check("arst_ec", 32'(err_count), 32'd0);
    check("arst_step_err", 32'({step, err}), 32'd0);
    apply(1, 4'b0111, 0);
    apply(0, 4'b0101, 0);
    @(negedge clk);
    rst_n = 1'b1;

    apply(1, to_gray(0), 0);
    apply(1, to_gray(15), 0);
    check("dn_first_pos", 32'(pos), 32'hFFFF);
    check("dn_first_dir", 32'(dir_up), 32'd0);
    for (int i = 2; i <= 70000; i++) apply(1, to_gray((70000 * 16 - i) % 16), 0);
    check("dn_final_pos", 32'(pos), 32'hEE90);

    for (int k = 1; k <= 260; k++) begin
      apply(1, to_gray(0), 1);
      apply(1, to_gray(0), 0);
      apply(1, to_gray(2), 0);
      if (k == 255 || k == 260) begin
        check("sat_err", 32'(err), 32'd1);
        check("sat_ec", 32'(err_count), 32'd255);
      end
    end
    apply(0, 4'b0000, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gray_pos_decoder.md
# gray_pos_decoder

Sequential Gray-code position decoder: the receiving end of a Gray-coded position/count source (e.g. a Gray counter or absolute encoder). Each valid Gray sample is converted to binary, checked against the previous sample for a legal single-step transition, and turned into step/direction pulses plus a wide accumulated position. Illegal multi-bit jumps raise an error and freeze tracking until an explicit resync. Sits downstream of the Gray/binary converter blocks, where a registered, checked position stream is needed.

## Interface

- WIDTH, 4, width of Gray input and binary output (≥2)
- POS_W, 16, width of accumulated position counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- gray_in  input  WIDTH  Gray-coded sample
- gray_valid  input  1  gray_in is sampled on this cycle
- resync  input  1  single-cycle request to drop the reference and re-acquire
- bin_out  output  WIDTH  binary of last accepted sample
- bin_valid  output  1  bin_out holds a tracked value
- step  output  1  one-cycle pulse: legal ±1 transition accepted
- dir_up  output  1  direction of last step (1 = +1, 0 = −1); held between steps
- pos  output  POS_W  signed two's-complement accumulated steps
- err  output  1  one-cycle pulse: illegal jump detected
- err_count  output  8  illegal jumps since reset, saturates at 255

## Operation

- Conversion: bin[WIDTH-1] = gray[WIDTH-1]; bin[i] = bin[i+1] ^ gray[i].
- States: SYNC (no reference), TRACK, FAULT. Reset → SYNC.
- SYNC, gray_valid=1: load bin_out with converted sample, bin_valid←1, → TRACK. No step, pos unchanged.
- TRACK, gray_valid=1: d = (new_bin − bin_out) mod 2^WIDTH.
  - d=0: no change, no pulse.
  - d=1: bin_out←new, step=1, dir_up=1, pos←pos+1.
  - d=2^WIDTH−1: bin_out←new, step=1, dir_up=0, pos←pos−1.
  - otherwise: err=1, err_count+1 (saturating), bin_valid←0, bin_out holds last good value, → FAULT.
- FAULT: all gray_valid samples ignored; stays until resync.
- resync (any state): → SYNC, bin_valid←0; bin_out, pos, dir_up, err_count hold.
- resync and gray_valid in the same cycle: resync wins, sample discarded.
- gray_valid=0: no state or output change; step/err are 0.
- Binary wrap (all-ones ↔ zero) is a legal ±1 step.
- pos wraps modulo 2^POS_W, no saturation; err_count saturates at 255 (the saturating event still pulses err).

## Timing

- All outputs registered; response appears the cycle after the sampling edge (latency 1).
- step and err are high for exactly one cycle per event, never together.
- Back-to-back gray_valid every cycle is supported: one decision per cycle, no bubbles.
- Reset (async assert, any time, including mid-stream): bin_out=0, bin_valid=0, step=0, dir_up=1, pos=0, err=0, err_count=0, state SYNC. The first edge after rst_n deasserts may sample normally.

## Test plan

- Reset, then gray_in=1011 valid → next cycle bin_out=1101, bin_valid=1, step=0, pos=0.
- From 1011, apply gray 1001 → bin_out=1110, step pulse, dir_up=1, pos=1; repeat 1001 → no pulse, pos=1.
- Up wrap: bin 1111 (gray 1000) then gray 0000 → bin_out=0000, step, dir_up=1, pos +1; then gray 1000 → bin_out=1111, step, dir_up=0, pos −1.
- Illegal jump: from gray 0000 apply gray 0011 (bin 0010) → err pulse, err_count=1, bin_valid=0, bin_out=0000; further samples ignored; resync with gray_valid high in the same cycle → sample dropped; next valid 0011 → bin_out=0010, bin_valid=1.
- Down-count 70000 cycles from pos=0 → pos wraps from 0 to 0xFFFF and continues; 260 illegal jumps, each followed by resync → err_count stops at 255, err still pulses.
- Assert rst_n low mid-stream with gray_valid toggling → all outputs at reset values immediately, independent of clk.
